// File: rtl/pixel_buffer_drain_pkg.sv
// rtl/pixel_buffer_drain_pkg.sv - shared pixel-buffer types and frame constants
package pixel_buffer_drain_pkg;

    localparam int PIXEL_ID_W = 19;
    localparam int NUM_PIXELS = 640 * 480;
    localparam int FB_ADDR_W  = 20;

    localparam logic [FB_ADDR_W-1:0] FB0_BASE = 20'h00000;
    localparam logic [FB_ADDR_W-1:0] FB1_BASE = 20'h4B000;

    typedef logic [PIXEL_ID_W-1:0] pixelID_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    typedef struct packed {
        pixelID_t pixelID;
        color_t   color;
    } pixel_buffer_entry_t;

    // Frame-buffer word layout: unused top byte, then r, g, b.
    function automatic logic [31:0] color_to_word(input color_t c);
        return {8'h00, c.r, c.g, c.b};
    endfunction

endpackage

// File: rtl/pixel_buffer_drain_if.sv
// rtl/pixel_buffer_drain_if.sv - shader write port and frame-buffer write handshake
interface pixel_buffer_drain_if #(
    parameter int ADDR_W = 20
);
    import pixel_buffer_drain_pkg::*;

    logic                pb_we;
    pixel_buffer_entry_t pb_data_in;
    logic                pb_full;
    logic                fb_valid;
    logic                fb_ready;
    logic [ADDR_W-1:0]   fb_addr;
    logic [31:0]         fb_data;

    // Shader and frame-buffer writer side
    modport master (
        output pb_we,
        output pb_data_in,
        output fb_ready,
        input  pb_full,
        input  fb_valid,
        input  fb_addr,
        input  fb_data
    );

    // Drain block side
    modport slave (
        input  pb_we,
        input  pb_data_in,
        input  fb_ready,
        output pb_full,
        output fb_valid,
        output fb_addr,
        output fb_data
    );

endinterface

// File: rtl/pixel_buffer_drain_ff_ar.sv
// rtl/pixel_buffer_drain_ff_ar.sv - enabled register with asynchronous active-high reset
module ff_ar #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; reset value applies immediately on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pixel_buffer_drain_pb_sync_fifo.sv
// rtl/pixel_buffer_drain_pb_sync_fifo.sv - synchronous FIFO, power-of-two depth, no bypass
module pb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A pop never frees a slot for a push in the same cycle while full.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign dout = mem[rd_ptr];

    // Occupancy tracks the net effect of this cycle's push and pop
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    ff_ar #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_ok),
        .d   (wr_ptr + 1'b1),
        .q   (wr_ptr)
    );

    ff_ar #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_ok),
        .d   (rd_ptr + 1'b1),
        .q   (rd_ptr)
    );

    ff_ar #(.W(CNT_W)) u_count (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (count_next),
        .q   (count)
    );

    // Storage is not reset; the reset pointers and count make stale words unreachable
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pixel_buffer_drain.sv
// rtl/pixel_buffer_drain.sv - buffers shader pixels and drains them to the frame-buffer writer
// Build macro PB_DOUBLE_BUFFER_EN: alternate between FB0_BASE and FB1_BASE every frame.
module pixel_buffer_drain #(
    parameter int                DEPTH      = 16,
    parameter int                NUM_PIXELS = pixel_buffer_drain_pkg::NUM_PIXELS,
    parameter int                ADDR_W     = 20,
    parameter logic [ADDR_W-1:0] FB0_BASE   = ADDR_W'(pixel_buffer_drain_pkg::FB0_BASE),
    parameter logic [ADDR_W-1:0] FB1_BASE   = ADDR_W'(pixel_buffer_drain_pkg::FB1_BASE)
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_buffer_drain_if.slave  bus,
    output logic                 frame_done,
    output logic                 buf_sel,
    output logic                 overflow_err
);

    import pixel_buffer_drain_pkg::*;

    localparam int ENTRY_W = $bits(pixel_buffer_entry_t);
    localparam int FCNT_W  = $clog2(DEPTH) + 1;
    localparam int CNT_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(DEPTH);

    logic [ENTRY_W-1:0]  head_raw;
    pixel_buffer_entry_t head;
    logic [FCNT_W-1:0]   fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                xfer;
    logic [CNT_W-1:0]    pix_cnt;
    logic                frame_last;
    logic [ADDR_W-1:0]   fb_base;

    assign bus.pb_full  = (fifo_count == DEPTH_C);
    assign bus.fb_valid = !fifo_empty;

    assign push = bus.pb_we && !bus.pb_full;
    assign xfer = bus.fb_valid && bus.fb_ready;

    pb_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (xfer),
        .din   (bus.pb_data_in),
        .dout  (head_raw),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = pixel_buffer_entry_t'(head_raw);

    // Outputs are forced to zero when idle so nothing from unwritten storage leaks out.
    assign fb_base     = buf_sel ? FB1_BASE : FB0_BASE;
    assign bus.fb_addr = bus.fb_valid ? (fb_base + ADDR_W'(head.pixelID)) : '0;
    assign bus.fb_data = bus.fb_valid ? color_to_word(head.color) : 32'h0;

    // A write attempted while full is dropped and latched as an error until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (bus.pb_we && fifo_full) begin
            overflow_err <= 1'b1;
        end
    end

    // Frame boundary is decided purely by how many words have been committed.
    assign frame_last = xfer && (pix_cnt == LAST_PIX);

    // Count committed pixels, wrapping and pulsing frame_done at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_last;
            if (frame_last) begin
                pix_cnt <= '0;
            end else if (xfer) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

`ifdef PB_DOUBLE_BUFFER_EN
    // Switch target buffer on the same edge that completes a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_sel <= 1'b0;
        end else if (frame_last) begin
            buf_sel <= ~buf_sel;
        end
    end
`else
    assign buf_sel = 1'b0;
`endif

endmodule
